// File: rtl/cpu_pkg.sv
// Shared CPU constants: MIPS instruction field positions, default NOP word and
// the IF/ID skid-buffer state encoding.
package cpu_pkg;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = EMPTY,
    StOne   = ONE,
    StFull  = FULL
  } ifid_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit MIPS word into its R/I-type fields.
// Shared by the IF/ID and ID/EX stages.
module instr_field_split
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  assign op    = instr[OP_HI:OP_LO];
  assign rs    = instr[RS_HI:RS_LO];
  assign rt    = instr[RT_HI:RT_LO];
  assign rd    = instr[RD_HI:RD_LO];
  assign shamt = instr[SHAMT_HI:SHAMT_LO];
  assign funct = instr[FUNCT_HI:FUNCT_LO];
  assign imm16 = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer (head H + skid S) and flush.
// Optional saturating stall/flush counters when IFID_PERF_CNT_EN is defined.
module if_id_skid_reg
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 32,
  parameter int unsigned           INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ADDR_W-1:0]  in_pc_i,
  input  logic [INSTR_W-1:0] in_instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ADDR_W-1:0]  out_pc_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [5:0]         out_op_o,
  output logic [4:0]         out_rs_o,
  output logic [4:0]         out_rt_o,
  output logic [4:0]         out_rd_o,
  output logic [4:0]         out_shamt_o,
  output logic [5:0]         out_funct_o,
  output logic [15:0]        out_imm16_o
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o
`endif
);

  ifid_state_e        state_q, state_d;
  logic               ready_q, ready_d;
  logic [ADDR_W-1:0]  h_pc_q, h_pc_d;
  logic [INSTR_W-1:0] h_instr_q, h_instr_d;
  logic [ADDR_W-1:0]  s_pc_q, s_pc_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;

  logic accept;
  logic pop;

  assign out_valid_o = (state_q != StEmpty);
  assign in_ready_o  = ready_q;
  assign accept      = in_valid_i && ready_q;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    state_d   = state_q;
    h_pc_d    = h_pc_q;
    h_instr_d = h_instr_q;
    s_pc_d    = s_pc_q;
    s_instr_d = s_instr_q;

    if (flush_i) begin
      // PCs keep their last value; instr words go back to NOP so fields read as 0.
      state_d   = StEmpty;
      h_instr_d = NOP_INSTR;
      s_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            h_pc_d    = in_pc_i;
            h_instr_d = in_instr_i;
          end
        end
        StOne: begin
          if (accept && !pop) begin
            state_d   = StFull;
            s_pc_d    = in_pc_i;
            s_instr_d = in_instr_i;
          end else if (pop && !accept) begin
            state_d   = StEmpty;
            h_instr_d = NOP_INSTR;
          end else if (accept && pop) begin
            h_pc_d    = in_pc_i;
            h_instr_d = in_instr_i;
          end
        end
        StFull: begin
          // ready_q is low here, so only a pop can move the state.
          if (pop) begin
            state_d   = StOne;
            h_pc_d    = s_pc_q;
            h_instr_d = s_instr_q;
            s_instr_d = NOP_INSTR;
          end
        end
        default: begin
          state_d   = StEmpty;
          h_instr_d = NOP_INSTR;
          s_instr_d = NOP_INSTR;
        end
      endcase
    end

    ready_d = (state_d != StFull);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= StEmpty;
      ready_q   <= 1'b1;
      h_pc_q    <= '0;
      h_instr_q <= NOP_INSTR;
      s_pc_q    <= '0;
      s_instr_q <= NOP_INSTR;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      h_pc_q    <= h_pc_d;
      h_instr_q <= h_instr_d;
      s_pc_q    <= s_pc_d;
      s_instr_q <= s_instr_d;
    end
  end

  assign out_pc_o    = h_pc_q;
  assign out_instr_o = h_instr_q;

  instr_field_split u_field_split (
    .instr (h_instr_q),
    .op    (out_op_o),
    .rs    (out_rs_o),
    .rt    (out_rt_o),
    .rd    (out_rd_o),
    .shamt (out_shamt_o),
    .funct (out_funct_o),
    .imm16 (out_imm16_o)
  );

`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_i && (state_q != StEmpty) && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline register with a 2-entry skid buffer, between instruction fetch and the decode stage.
- Splits the held instruction into MIPS fields.
- Its 16-bit immediate output drives Sign_Extend directly; its register fields drive the register file and control unit.
- Valid/ready handshakes on both sides, plus a synchronous flush for taken branches and jumps.

Parameters:
- ADDR_W, 32, PC width.
- INSTR_W, 32, instruction width; fixed at 32 for field decode.
- NOP_INSTR, 32'h0000_0000, value driven on out_instr_o while the output is empty.

Ports:
- CLK  input  1  clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush, discards all held entries.
- in_valid_i  input  1  fetch has a valid instruction.
- in_ready_o  input-side output  1  block can accept.
- in_pc_i  input  ADDR_W  PC of the incoming instruction.
- in_instr_i  input  INSTR_W  incoming instruction.
- out_valid_o  output  1  head entry is valid.
- out_ready_i  input  1  decode consumes the head.
- out_pc_o  output  ADDR_W  head PC.
- out_instr_o  output  INSTR_W  head instruction.
- out_op_o  output  6  instr[31:26].
- out_rs_o  output  5  instr[25:21].
- out_rt_o  output  5  instr[20:16].
- out_rd_o  output  5  instr[15:11].
- out_shamt_o  output  5  instr[10:6].
- out_funct_o  output  6  instr[5:0].
- out_imm16_o  output  16  instr[15:0], to Sign_Extend.

Behaviour:
- Clock/reset: one clock, CLK. Reset is asynchronous, active-low (RST_n).
- Reset values:
  - out_valid_o=0, in_ready_o=1.
  - Both entries invalid; head/skid PC = 0; head/skid instr = NOP_INSTR.
  - All field outputs are therefore 0.
- Storage: head register (H) drives outputs; skid register (S) holds one overflow entry.
- States: EMPTY (H invalid, S invalid), ONE (H valid, S invalid), FULL (H valid, S valid).
- Handshake:
  - Accept when in_valid_i && in_ready_o.
  - Pop when out_valid_o && out_ready_i.
- Ready/valid timing:
  - in_ready_o = (state != FULL), registered; it never depends combinationally on out_ready_i.
  - out_valid_o = (state != EMPTY).
- Transitions, per rising edge with flush_i=0:
  - EMPTY: accept goes to ONE, data loads into H.
  - ONE: accept without pop goes to FULL, data into S. Pop without accept goes to EMPTY. Accept with pop stays ONE, new data into H.
  - FULL: no accept is possible. Pop goes to ONE and S moves to H.
- Latency: accept at edge N makes the entry visible on the outputs after edge N. Minimum latency is 1 cycle.
- Throughput: 1 instruction/cycle while out_ready_i=1.
- Ordering: strict FIFO; S is never emitted before H.
- Flush:
  - flush_i=1 at an edge forces EMPTY; any entry accepted on that same edge is discarded.
  - Fetch may still see in_ready_o=1 during the flush cycle; the handshake counts, but the data is dropped.
  - flush_i has priority over accept and pop.
- Field outputs: purely combinational slices of H's instr.
- Empty output: out_instr_o = NOP_INSTR, out_pc_o holds its last value; consumers must qualify with out_valid_o.
- Reset mid-operation: asynchronously returns to reset values regardless of state; no partial entry survives.
- in_pc_i is not checked or altered; PC wrap at 32'hFFFF_FFFC passes through unchanged.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- With the macro:
  - Adds output stall_cnt_o[15:0], reset 0.
  - Increments on every edge where out_valid_o=1 && out_ready_i=0, saturating at 16'hFFFF.
  - Adds output flush_cnt_o[15:0], reset 0, incremented on every edge with flush_i=1 while state != EMPTY, saturating.
- Without the macro: neither port nor counter exists, and the logic is identical otherwise.

Decomposition:
- Shared package (cpu_pkg):
  - Field bit-position constants: OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO.
  - NOP_INSTR default.
  - State encoding localparams: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Sub-module: one natural sub-module, instr_field_split, a combinational decode of a 32-bit word into the seven fields, reused later by the ID/EX stage. The storage/FSM stays in the top module.

Test Plan:
- Reset:
  - Stimulus: RST_n=0 mid-run with state FULL.
  - Response: out_valid_o=0 and in_ready_o=1 immediately; out_instr_o=32'h0 before the next edge.
- Streaming:
  - Stimulus: out_ready_i=1; instr 32'h2008_8000 at pc 0x0, then 32'h2009_0008 at pc 0x4.
  - Response: one cycle later out_imm16_o=16'h8000, out_rt_o=8; next cycle 16'h0008, rt=9; no bubbles.
- Backpressure:
  - Stimulus: out_ready_i=0; push A, B, C.
  - Response: A in H, B in S, in_ready_o=0; C is not accepted and fetch holds it. After out_ready_i=1, emits A, B, C in order.
- Flush:
  - Stimulus: FULL with A, B, then flush_i=1 while in_valid_i=1 with C.
  - Response: next cycle out_valid_o=0 and C is absent. An entry pushed after the flush appears normally.
- Simultaneous push/pop in ONE:
  - Response: state stays ONE, head replaced by the new entry, no duplicate and no drop.
- IFID_PERF_CNT_EN:
  - Stimulus: 5 stalled cycles, then 1 flush with data held.
  - Response: stall_cnt_o=5, flush_cnt_o=1.
